// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and imem (slave).
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input  ack, rdata);
  modport slave  (input  req, addr, output ack, rdata);
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: holds the PC, fetches one instruction at a time over req/ack and presents it until consumed.
// Optional macro MISALIGN_TRAP_EN: a misaligned branch/jump target traps (sticky fetch_err) instead of being aligned.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_if.master       imem,
  input  logic                stall,
  input  logic                pc_src,
  input  logic [31:0]         pc_target,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [31:0]         pc,
  output logic [6:0]          op,
  output logic [2:0]          f3,
  output logic [6:0]          f7,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic                fetch_err
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1
`ifdef MISALIGN_TRAP_EN
    , TRAP = 2'd2
`endif
  } state_t;

  state_t      state, nextState;
  logic        consume;
  logic        ackTaken;
  logic [31:0] pcNext;

  assign ackTaken = (state == REQ) && imem.ack;
  assign consume  = (state == HOLD) && instr_valid && !stall;

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = pc_src && (pc_target[1:0] != 2'b00);
  // The faulting target is kept verbatim so the trap handler can see it.
  assign pcNext   = pc_src ? pc_target : pc + 32'd4;
`else
  assign pcNext   = pc_src ? (pc_target & 32'hFFFF_FFFC) : pc + 32'd4;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= REQ;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      REQ:  if (imem.ack) nextState = HOLD;
      HOLD: if (consume) begin
        nextState = REQ;
`ifdef MISALIGN_TRAP_EN
        if (misalign) nextState = TRAP;
`endif
      end
      default: nextState = state;
    endcase
  end

  // Outputs: request is suppressed combinationally during reset
  always_comb begin
    imem.req  = 1'b0;
    imem.addr = pc;
    if (rst_n && state == REQ) imem.req = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else if (ackTaken) begin
      instr       <= imem.rdata;
      instr_valid <= 1'b1;
    end else if (consume) begin
      pc          <= pcNext;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                   fetch_err <= 1'b0;
    else if (consume && misalign) fetch_err <= 1'b1;
  end
`else
  assign fetch_err = 1'b0;
`endif

  assign op  = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: main process drives directed fetches, monitor checks each request and each new instruction.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fetch_err;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (bus),
    .stall       (stall),
    .pc_src      (pc_src),
    .pc_target   (pc_target),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .op          (op),
    .f3          (f3),
    .f7          (f7),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .fetch_err   (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          total = 0;
  int          passed = 0;
  exp_t        expQ[$];
  logic [31:0] addrQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [31:0] w, input logic [6:0] o,
                              input logic [4:0] d, input logic [2:0] fn3, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [6:0] fn7);
    exp_t e;
    e.pc = p; e.instr = w; e.op = o; e.rd = d; e.f3 = fn3; e.rs1 = s1; e.rs2 = s2; e.f7 = fn7;
    return e;
  endfunction

  // Monitor: new request -> compare address; new valid instruction -> compare word and fields
  initial begin
    logic prevReq, prevValid;
    exp_t e;
    prevReq = 1'b0;
    prevValid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.req && !prevReq) begin
        if (addrQ.size() == 0) check("unexpected req", bus.addr, 32'hFFFF_FFFF);
        else check("req addr", bus.addr, addrQ.pop_front());
      end
      if (instr_valid && !prevValid) begin
        if (expQ.size() == 0) check("unexpected valid", instr, 32'hFFFF_FFFF);
        else begin
          e = expQ.pop_front();
          check("pc", pc, e.pc);
          check("instr", instr, e.instr);
          check("op", 32'(op), 32'(e.op));
          check("rd", 32'(rd), 32'(e.rd));
          check("f3", 32'(f3), 32'(e.f3));
          check("rs1", 32'(rs1), 32'(e.rs1));
          check("rs2", 32'(rs2), 32'(e.rs2));
          check("f7", 32'(f7), 32'(e.f7));
        end
      end
      prevReq = bus.req;
      prevValid = instr_valid;
    end
  end

  // Wait for a request, then ack after waitCycles extra REQ cycles.
  task automatic serve(input int waitCycles, input logic [31:0] data);
    int n = 0;
    while (!bus.req && n < 20) begin @(negedge clk); n++; end
    check("req seen", 32'(bus.req), 32'd1);
    repeat (waitCycles) @(negedge clk);
    bus.ack = 1'b1;
    bus.rdata = data;
    @(negedge clk);
    bus.ack = 1'b0;
    bus.rdata = 32'h0;
  endtask

  task automatic waitValid();
    int n = 0;
    while (!instr_valid && n < 20) begin @(negedge clk); n++; end
    check("valid seen", 32'(instr_valid), 32'd1);
  endtask

  // Drop stall for exactly one cycle; check the request timing right after.
  task automatic consume(input logic src, input logic [31:0] tgt, input logic expectReq);
    waitValid();
    pc_src = src;
    pc_target = tgt;
    stall = 1'b0;
    #1 check("no req in consume cycle", 32'(bus.req), 32'd0);
    @(negedge clk);
    stall = 1'b1;
    pc_src = 1'b0;
    pc_target = 32'hBAD0_0001;
    check("req after consume", 32'(bus.req), 32'(expectReq));
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b1;
    pc_src = 1'b0;
    pc_target = 32'h0;
    bus.ack = 1'b0;
    bus.rdata = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst valid", 32'(instr_valid), 32'd0);
    check("rst instr", instr, 32'h0000_0013);
    check("rst pc", pc, 32'h0);
    check("rst req", 32'(bus.req), 32'd0);
    check("rst err", 32'(fetch_err), 32'd0);
    check("rst op", 32'(op), 32'h13);

    // First fetch: addi x1,x0,2 acked one cycle after the request
    addrQ.push_back(32'h0);
    expQ.push_back(mk(32'h0, 32'h0020_0093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd2, 7'd0));
    rst_n = 1'b1;
    serve(1, 32'h0020_0093);
    waitValid();

    // Stall: everything held despite pc_src/pc_target churn and spurious acks
    for (int i = 0; i < 5; i++) begin
      check("stall instr", instr, 32'h0020_0093);
      check("stall pc", pc, 32'h0);
      check("stall valid", 32'(instr_valid), 32'd1);
      check("stall req", 32'(bus.req), 32'd0);
      pc_src = i[0];
      pc_target = 32'h100 + 32'(i * 4);
      bus.ack = i[0];
      bus.rdata = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    bus.ack = 1'b0;
    check("stall end instr", instr, 32'h0020_0093);

    // Sequential advance to 4: addi x2,x0,4 acked in the first REQ cycle
    addrQ.push_back(32'h4);
    expQ.push_back(mk(32'h4, 32'h0040_0113, 7'h13, 5'd2, 3'd0, 5'd0, 5'd4, 7'd0));
    consume(1'b0, 32'h0, 1'b1);
    serve(0, 32'h0040_0113);

    // Taken branch to 0x40, R-type sub x0,x0,x0
    addrQ.push_back(32'h40);
    expQ.push_back(mk(32'h40, 32'h4000_0033, 7'd51, 5'd0, 3'd0, 5'd0, 5'd0, 7'b0100000));
    consume(1'b1, 32'h40, 1'b1);
    serve(2, 32'h4000_0033);

    // Jump to top of memory, then PC+4 wraps to 0
    addrQ.push_back(32'hFFFF_FFFC);
    expQ.push_back(mk(32'hFFFF_FFFC, 32'h0020_81B3, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0));
    consume(1'b1, 32'hFFFF_FFFC, 1'b1);
    serve(1, 32'h0020_81B3);
    addrQ.push_back(32'h0);
    consume(1'b0, 32'h0, 1'b1);
    check("wrap addr", bus.addr, 32'h0);

    // Reset while requesting, with an ack in the same cycle
    rst_n = 1'b0;
    bus.ack = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    #1 check("req in reset", 32'(bus.req), 32'd0);
    @(negedge clk);
    bus.ack = 1'b0;
    check("rst2 valid", 32'(instr_valid), 32'd0);
    check("rst2 pc", pc, 32'h0);
    check("rst2 instr", instr, 32'h0000_0013);
    addrQ.push_back(32'h0);
    expQ.push_back(mk(32'h0, 32'h0030_0193, 7'h13, 5'd3, 3'd0, 5'd0, 5'd3, 7'd0));
    rst_n = 1'b1;
    serve(0, 32'h0030_0193);

    // Misaligned target 0x46
`ifdef MISALIGN_TRAP_EN
    consume(1'b1, 32'h46, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("trap err", 32'(fetch_err), 32'd1);
      check("trap req", 32'(bus.req), 32'd0);
      check("trap valid", 32'(instr_valid), 32'd0);
      check("trap pc", pc, 32'h46);
      @(negedge clk);
    end
`else
    addrQ.push_back(32'h44);
    expQ.push_back(mk(32'h44, 32'h0000_0013, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0));
    consume(1'b1, 32'h46, 1'b1);
    check("aligned addr", bus.addr, 32'h44);
    serve(1, 32'h0000_0013);
    waitValid();
    check("no err", 32'(fetch_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("exp queue drained", 32'(expQ.size()), 32'd0);
    check("addr queue drained", 32'(addrQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
